// File: rtl/icache_pkg.sv
// ============================================================================
// icache_pkg : shared types and address-split helpers for the icache_responder
// Revision   : 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } icache_state_e;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned BYTE_BITS = 2;

   function automatic int unsigned word_bits(input int unsigned line_words);
      return $clog2(line_words);
   endfunction

   function automatic int unsigned index_bits(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_bits(input int unsigned line_words,
                                            input int unsigned num_lines);
      return ADDR_W - BYTE_BITS - word_bits(line_words) - index_bits(num_lines);
   endfunction

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// icache_array : tag/valid/data storage, combinational read, synchronous write
// Revision     : 1.0
// ============================================================================
`default_nettype none

module icache_array
   import icache_pkg::*;
#(
   parameter  int unsigned LINE_WORDS = 4,
   parameter  int unsigned NUM_LINES  = 16,
   parameter  int unsigned TAG_W      = 24,
   localparam int unsigned WORD_W     = word_bits(LINE_WORDS),
   localparam int unsigned IDX_W      = index_bits(NUM_LINES)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inv_i,
   input  logic [IDX_W-1:0]  rd_index_i,
   input  logic [WORD_W-1:0] rd_word_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [31:0]       rd_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_index_i,
   input  logic [WORD_W-1:0] wr_word_i,
   input  logic [31:0]       wr_data_i,
   input  logic              fill_done_i,
   input  logic [TAG_W-1:0]  wr_tag_i
);

   logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] valid_d;

   // A completing fill wins over a same-cycle invalidate for its own line.
   always_comb begin
      valid_d = valid_q;
      if (inv_i)
         valid_d = '0;
      if (fill_done_i)
         valid_d[wr_index_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         valid_q <= '0;
      else
         valid_q <= valid_d;
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i)
         data_q[wr_index_i][wr_word_i] <= wr_data_i;
      if (fill_done_i)
         tag_q[wr_index_i] <= wr_tag_i;
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i][rd_word_i];

endmodule

`default_nettype wire

// File: rtl/icache_responder.sv
// ============================================================================
// icache_responder : direct-mapped read-only instruction cache with line refill
//                    Optional hit/miss counters under ICACHE_STATS_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module icache_responder
   import icache_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned NUM_LINES  = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_f_i,
   input  logic        inv_i,
   output logic [31:0] instr_f_o,
   output logic        miss_stall_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o
`endif
);

   localparam int unsigned WORD_W = word_bits(LINE_WORDS);
   localparam int unsigned IDX_W  = index_bits(NUM_LINES);
   localparam int unsigned TAG_W  = tag_bits(LINE_WORDS, NUM_LINES);
   localparam int unsigned LINE_W = IDX_W + TAG_W;

   icache_state_e     state_q, state_d;
   logic [WORD_W-1:0] beat_q, beat_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              mem_req_q, mem_req_d;
   logic [31:0]       mem_addr_q, mem_addr_d;

   logic [WORD_W-1:0] pc_word;
   logic [IDX_W-1:0]  pc_index;
   logic [TAG_W-1:0]  pc_tag;
   logic [LINE_W-1:0] pc_line;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic              hit;
   logic              beat_accept;
   logic              last_beat;
   logic              unused_pc;

   assign pc_word   = pc_f_i[BYTE_BITS +: WORD_W];
   assign pc_index  = pc_f_i[BYTE_BITS + WORD_W +: IDX_W];
   assign pc_tag    = pc_f_i[31 -: TAG_W];
   assign pc_line   = pc_f_i[31 -: LINE_W];
   assign unused_pc = ^pc_f_i[1:0];

   assign hit          = (state_q == IDLE) && rd_valid && (rd_tag == pc_tag);
   assign miss_stall_o = !hit;
   assign beat_accept  = (state_q == REFILL) && mem_ready_i;
   assign last_beat    = (beat_q == WORD_W'(LINE_WORDS - 1));
   assign mem_req_o    = mem_req_q;
   assign mem_addr_o   = mem_addr_q;

   icache_array #(
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES),
      .TAG_W      (TAG_W)
   ) u_array (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inv_i       (inv_i),
      .rd_index_i  (pc_index),
      .rd_word_i   (pc_word),
      .rd_valid_o  (rd_valid),
      .rd_tag_o    (rd_tag),
      .rd_data_o   (instr_f_o),
      .wr_en_i     (beat_accept),
      .wr_index_i  (line_q[IDX_W-1:0]),
      .wr_word_i   (beat_q),
      .wr_data_i   (mem_rdata_i),
      .fill_done_i (beat_accept && last_beat),
      .wr_tag_i    (line_q[LINE_W-1 -: TAG_W])
   );

   // Request and address are precomputed for the next cycle so both leave as flops.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      line_d     = line_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         IDLE: begin
            if (!hit) begin
               state_d    = REFILL;
               line_d     = pc_line;
               beat_d     = '0;
               mem_req_d  = 1'b1;
               mem_addr_d = {pc_line, {WORD_W{1'b0}}, 2'b00};
            end
         end
         REFILL: begin
            if (mem_ready_i) begin
               beat_d = beat_q + WORD_W'(1);
               if (last_beat) begin
                  state_d    = IDLE;
                  mem_req_d  = 1'b0;
                  mem_addr_d = '0;
               end else begin
                  mem_addr_d = {line_q, beat_d, 2'b00};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         line_q     <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         line_q     <= line_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (hit && (hit_count_q != '1))
         hit_count_d = hit_count_q + 32'd1;
      if ((state_q == IDLE) && !hit && (miss_count_q != '1))
         miss_count_d = miss_count_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count_o  = hit_count_q;
   assign miss_count_o = miss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_responder.sv
// ============================================================================
// tb_icache_responder : directed scoreboard bench for icache_responder
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_icache_responder;

   localparam int LW = 4;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] pc_f_i;
   logic        inv_i;
   logic [31:0] instr_f_o;
   logic        miss_stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ready_i;
   logic [31:0] mem_rdata_i;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int          n_pass;
   int          n_total;
   int          wait_cycles;
   logic [31:0] exp_instr_q[$];
   logic [31:0] exp_addr_q[$];

   icache_responder #(
      .LINE_WORDS (LW),
      .NUM_LINES  (16)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pc_f_i       (pc_f_i),
      .inv_i        (inv_i),
      .instr_f_o    (instr_f_o),
      .miss_stall_o (miss_stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_ready_i  (mem_ready_i),
      .mem_rdata_i  (mem_rdata_i)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count_o  (hit_count),
      .miss_count_o (miss_count)
`endif
   );

   // Memory model: each word holds its own word address.
   assign mem_rdata_i = mem_addr_o >> 2;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic fetch(input logic [31:0] pc, input int exp_stall, input logic [31:0] exp_instr);
      int          stalls = 0;
      int          wcnt   = 0;
      bit          done   = 0;
      bit          timeout = 0;
      logic [31:0] exp_a;
      pc_f_i = pc;
      exp_instr_q.push_back(exp_instr);
      if (exp_stall > 0)
         for (int k = 0; k < LW; k++)
            exp_addr_q.push_back({pc[31:4], 4'h0} + 32'(4 * k));
      while (!done) begin
         mem_ready_i = mem_req_o && (wcnt == wait_cycles);
         @(negedge clk_i);
         if (!miss_stall_o) begin
            done = 1;
         end else begin
            stalls++;
            if (mem_req_o) begin
               if (exp_addr_q.size() == 0) begin
                  check("unexpected_req", mem_addr_o, 32'hFFFF_FFFF);
               end else if (mem_ready_i) begin
                  exp_a = exp_addr_q.pop_front();
                  check("beat_addr", mem_addr_o, exp_a);
               end else begin
                  check("held_addr", mem_addr_o, exp_addr_q[0]);
               end
               wcnt = mem_ready_i ? 0 : wcnt + 1;
            end
            if (stalls > 64) begin
               timeout = 1;
               done    = 1;
            end
         end
         if (!done) begin
            @(posedge clk_i);
            #1;
         end
      end
      check("stall_cycles", 32'(stalls), 32'(exp_stall));
      check("beats_issued", 32'(exp_addr_q.size()), 32'd0);
      exp_a = exp_instr_q.pop_front();
      if (!timeout)
         check("instr", instr_f_o, exp_a);
      exp_addr_q.delete();
      mem_ready_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      n_pass      = 0;
      n_total     = 0;
      wait_cycles = 0;
      rst_i       = 1'b1;
      pc_f_i      = 32'h0000_0040;
      inv_i       = 1'b0;
      mem_ready_i = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("reset_req", {31'd0, mem_req_o}, 32'd0);
      check("reset_addr", mem_addr_o, 32'd0);
      check("reset_stall", {31'd0, miss_stall_o}, 32'd1);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Cold miss, then hits in the same line
      fetch(32'h0000_0040, 5, 32'h10);
      fetch(32'h0000_0044, 0, 32'h11);
      fetch(32'h0000_0048, 0, 32'h12);
      fetch(32'h0000_004C, 0, 32'h13);
`ifdef ICACHE_STATS_EN
      check("miss_count", miss_count, 32'd1);
      check("hit_count", hit_count, 32'd4);
`endif

      // Conflict eviction on index 4
      fetch(32'h0000_0140, 5, 32'h50);
      fetch(32'h0000_0040, 5, 32'h10);

      // Backpressure: three wait cycles before every beat
      wait_cycles = 3;
      fetch(32'h0000_0088, 17, 32'h22);
      wait_cycles = 0;
      fetch(32'h0000_0084, 0, 32'h21);

      // Invalidate on a hit cycle
      pc_f_i = 32'h0000_0040;
      inv_i  = 1'b1;
      @(negedge clk_i);
      check("inv_hit_stall", {31'd0, miss_stall_o}, 32'd0);
      check("inv_hit_instr", instr_f_o, 32'h10);
      @(posedge clk_i);
      #1;
      inv_i       = 1'b0;
      mem_ready_i = 1'b1;
      @(negedge clk_i);
      check("inv_next_miss", {31'd0, miss_stall_o}, 32'd1);

      // Reset while beat 2 is on the bus
      repeat (3) begin
         @(posedge clk_i);
         #1;
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      check("beat2_addr", mem_addr_o, 32'h0000_0048);
      check("beat2_req", {31'd0, mem_req_o}, 32'd1);
      @(posedge clk_i);
      #1;
      mem_ready_i = 1'b0;
      @(negedge clk_i);
      check("abort_req", {31'd0, mem_req_o}, 32'd0);
      check("abort_addr", mem_addr_o, 32'd0);
      check("abort_stall", {31'd0, miss_stall_o}, 32'd1);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      fetch(32'h0000_0040, 5, 32'h10);
      fetch(32'h0000_0088, 5, 32'h22);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
